// File: rtl/ssa_inverse_ntt.sv
// Iterative 16-point inverse NTT over GF(257): bit-reversed load, 32 radix-2 DIT
// butterflies (one per cycle), then 16 cycles of scaling by N^-1 = 241.
module ssa_inverse_ntt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [143:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [143:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BFLY, SCALE, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [8:0]  a_q [16];
  logic [8:0]  a_d [16];

  logic [1:0]  stg;
  logic [2:0]  j;
  logic [3:0]  top, bot;
  logic [2:0]  tw_idx;
  logic [8:0]  mul_x, mul_y, prod;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // 129^e mod 257; butterfly exponents never exceed 7
  function automatic logic [8:0] twiddle(input logic [2:0] e);
    logic [8:0] w;
    case (e)
      3'd0:    w = 9'd1;
      3'd1:    w = 9'd129;
      3'd2:    w = 9'd193;
      3'd3:    w = 9'd225;
      3'd4:    w = 9'd241;
      3'd5:    w = 9'd249;
      3'd6:    w = 9'd253;
      default: w = 9'd255;
    endcase
    return w;
  endfunction

  function automatic logic [8:0] reduce_in(input logic [8:0] x);
    return (x >= 9'd257) ? x - 9'd257 : x;
  endfunction

  // 2^8 = -1 and 2^16 = 1 (mod 257), so fold the product as lo - mid + hi
  function automatic logic [8:0] mod_mul(input logic [8:0] x, input logic [8:0] y);
    logic [16:0]        p;
    logic signed [10:0] r;
    p = x * y;
    r = $signed({3'b000, p[7:0]}) - $signed({3'b000, p[15:8]}) + $signed({10'b0, p[16]});
    if (r < 0) r = r + 11'sd257;
    return r[8:0];
  endfunction

  function automatic logic [8:0] mod_add(input logic [8:0] x, input logic [8:0] y);
    logic [9:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 10'd257) s = s - 10'd257;
    return s[8:0];
  endfunction

  function automatic logic [8:0] mod_sub(input logic [8:0] x, input logic [8:0] y);
    logic [9:0] d;
    d = {1'b0, x} + 10'd257 - {1'b0, y};
    if (d >= 10'd257) d = d - 10'd257;
    return d[8:0];
  endfunction

  assign stg = cnt_q[4:3];
  assign j   = cnt_q[2:0];

  // top inserts a zero at bit position s of j; twiddle exponent is pos << (3-s)
  always_comb begin
    top    = 4'd0;
    tw_idx = 3'd0;
    case (stg)
      2'd0:    begin top = {j, 1'b0};               tw_idx = 3'd0;           end
      2'd1:    begin top = {j[2:1], 1'b0, j[0]};    tw_idx = {j[0], 2'b00};  end
      2'd2:    begin top = {j[2], 1'b0, j[1:0]};    tw_idx = {j[1:0], 1'b0}; end
      default: begin top = {1'b0, j};               tw_idx = j;              end
    endcase
  end

  assign bot = top | (4'd1 << stg);

  // single modular multiplier shared by butterfly and scaling phases
  assign mul_x = (state_q == SCALE) ? 9'd241 : twiddle(tw_idx);
  assign mul_y = (state_q == SCALE) ? a_q[cnt_q[3:0]] : a_q[bot];
  assign prod  = mod_mul(mul_x, mul_y);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int k = 0; k < 16; k++) begin
            a_d[bitrev4(4'(k))] = reduce_in(in_data[9*k +: 9]);
          end
          cnt_d   = 5'd0;
          state_d = BFLY;
        end
      end
      BFLY: begin
        busy     = 1'b1;
        a_d[top] = mod_add(a_q[top], prod);
        a_d[bot] = mod_sub(a_q[top], prod);
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = SCALE;
        end
      end
      SCALE: begin
        busy              = 1'b1;
        a_d[cnt_q[3:0]]   = prod;
        cnt_d             = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          cnt_d   = 5'd0;
          state_d = DONE;
        end
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      for (int k = 0; k < 16; k++) a_q[k] <= 9'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign out_data[9*g +: 9] = a_q[g];
  end

endmodule

// File: tb/tb_ssa_inverse_ntt.sv
// Directed bench for ssa_inverse_ntt: hand-computed GF(257) inverse transforms,
// latency, reset abort and output backpressure.
module tb_ssa_inverse_ntt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [143:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int asserts = 0;
  int fails   = 0;

  logic [8:0] vin  [16];
  logic [8:0] vexp [16];

  ssa_inverse_ntt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] pack_in();
    logic [143:0] v;
    for (int k = 0; k < 16; k++) v[9*k +: 9] = vin[k];
    return v;
  endfunction

  function automatic logic [143:0] pack_exp();
    logic [143:0] v;
    for (int k = 0; k < 16; k++) v[9*k +: 9] = vexp[k];
    return v;
  endfunction

  task automatic set_in_all(input logic [8:0] v);
    for (int k = 0; k < 16; k++) vin[k] = v;
  endtask

  task automatic set_exp_delta(input int lane, input logic [8:0] v);
    for (int k = 0; k < 16; k++) vexp[k] = 9'd0;
    vexp[lane] = v;
  endtask

  // drive vin for one cycle; the following edge is the accept edge
  task automatic send_vec();
    @(posedge clk); #1;
    in_data  = pack_in();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 144'd0) begin
      fails++;
      $display("FAIL reset_during: ov/busy/ir=%b data=%h expected 001 and 0", {out_valid, busy, in_ready}, out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 144'd0) begin
      fails++;
      $display("FAIL reset_after: ov/busy/ir=%b data=%h expected 001 and 0", {out_valid, busy, in_ready}, out_data);
    end
  endtask

  task automatic test_flat();
    int cyc; bit to;
    set_in_all(9'd1); set_exp_delta(0, 9'd1);
    send_vec();
    asserts++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flat_busy: busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    wait_done(cyc, to);
    // cyc counts edges after the accept edge until out_valid is seen
    asserts++;
    if (to || cyc !== 48) begin
      fails++;
      $display("FAIL flat_latency: got %0d cycles (timeout=%0d) expected 48", cyc, to);
    end
    asserts++;
    if (out_data !== pack_exp()) begin
      fails++;
      $display("FAIL flat_data: got %h expected %h", out_data, pack_exp());
    end
    release_out();
    asserts++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flat_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_dc();
    int cyc; bit to;
    set_in_all(9'd0); vin[0] = 9'd16;
    for (int k = 0; k < 16; k++) vexp[k] = 9'd1;
    send_vec();
    wait_done(cyc, to);
    asserts++;
    if (to || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL dc_data: got %h (timeout=%0d) expected %h", out_data, to, pack_exp());
    end
    release_out();
  endtask

  task automatic test_shifted_delta();
    int cyc; bit to; int p;
    p = 1;
    for (int k = 0; k < 16; k++) begin
      vin[k] = 9'(p);
      p = (p * 2) % 257;
    end
    set_exp_delta(1, 9'd1);
    send_vec();
    wait_done(cyc, to);
    asserts++;
    if (to || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL delta_data: got %h (timeout=%0d) expected %h", out_data, to, pack_exp());
    end
    release_out();
  endtask

  task automatic test_unreduced();
    int cyc; bit to;
    set_in_all(9'd258); set_exp_delta(0, 9'd1);
    send_vec();
    wait_done(cyc, to);
    asserts++;
    if (to || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL unreduced_258: got %h (timeout=%0d) expected %h", out_data, to, pack_exp());
    end
    release_out();
    set_in_all(9'd511); set_exp_delta(0, 9'd254);
    send_vec();
    wait_done(cyc, to);
    asserts++;
    if (to || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL unreduced_511: got %h (timeout=%0d) expected %h", out_data, to, pack_exp());
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    set_in_all(9'd1);
    send_vec();
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    asserts++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 144'd0) begin
      fails++;
      $display("FAIL midreset_abort: ov/busy/ir=%b data=%h expected 001 and 0", {out_valid, busy, in_ready}, out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL midreset_idle: ov/busy/ir=%b expected 001", {out_valid, busy, in_ready});
    end
    set_exp_delta(0, 9'd1);
    send_vec();
    wait_done(cyc, to);
    asserts++;
    if (to || cyc !== 48 || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL midreset_rerun: got %h cyc=%0d (timeout=%0d) expected %h cyc=48", out_data, cyc, to, pack_exp());
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [143:0] dc_vec;
    set_in_all(9'd0); vin[0] = 9'd16;
    dc_vec = pack_in();
    set_in_all(9'd1); set_exp_delta(0, 9'd1);
    send_vec();
    repeat (4) @(posedge clk);
    #1;
    // stray request while busy must not disturb the running transform
    in_data  = dc_vec;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc, to);
    asserts++;
    if (to || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL bp_ignore_busy: got %h (timeout=%0d) expected %h", out_data, to, pack_exp());
    end
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      asserts++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== pack_exp()) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: ov=%b ir=%b data=%h expected 1 0 %h", i, out_valid, in_ready, out_data, pack_exp());
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    asserts++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    asserts++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_accept: busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    for (int k = 0; k < 16; k++) vexp[k] = 9'd1;
    wait_done(cyc, to);
    asserts++;
    if (to || cyc !== 48 || out_data !== pack_exp()) begin
      fails++;
      $display("FAIL bp_next_data: got %h cyc=%0d (timeout=%0d) expected %h cyc=48", out_data, cyc, to, pack_exp());
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_flat();
    test_dc();
    test_shifted_delta();
    test_unreduced();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
